// File: rtl/crm_seq_if.sv
// crm_seq_if: groups the divider control, software reset request and the sequenced reset outputs of crm_seq
//   PCLK_DIV    : requested PCLKEN period minus one
//   SW_RST_REQ  : software reset request
//   PCLKEN      : APB-domain clock-enable strobe
//   SYS_ARESETN : sequenced AXI-domain reset, active-low
//   SYS_PRESETN : sequenced APB-domain reset, active-low
//   RST_BUSY    : high while the sequence has not reached RUN
interface crm_seq_if;
  logic [3:0] PCLK_DIV;
  logic       SW_RST_REQ;
  logic       PCLKEN;
  logic       SYS_ARESETN;
  logic       SYS_PRESETN;
  logic       RST_BUSY;
  modport master (output PCLK_DIV, SW_RST_REQ, input PCLKEN, SYS_ARESETN, SYS_PRESETN, RST_BUSY);
  modport slave (input PCLK_DIV, SW_RST_REQ, output PCLKEN, SYS_ARESETN, SYS_PRESETN, RST_BUSY);
endinterface

// File: rtl/crm_seq.sv
// crm_seq: clock-enable divider plus AXI/APB system reset sequencer
//   ACLK    : single clock, rising edge
//   ARESETN : asynchronous active-low reset, deasserted synchronously upstream
//   bus     : crm_seq_if slave (PCLK_DIV, SW_RST_REQ in; PCLKEN, SYS_ARESETN, SYS_PRESETN, RST_BUSY out)
module crm_seq #(
  parameter int         HOLD_CYCLES = 16,
  parameter int         PA_GAP      = 4,
  parameter logic [3:0] DEF_DIV     = 4'd1
) (
  input logic      ACLK,
  input logic      ARESETN,
  crm_seq_if.slave bus
);
  typedef enum logic [1:0] {ASSERT, REL_A, WAIT_P, RUN} state_t;
  logic [3:0] r_cnt, r_div_q;
  logic       w_tick;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_hc, w_hc_nxt;
  logic       r_sys_a, r_sys_p;
  assign w_tick = r_cnt == r_div_q;
  // The divider only reloads on its own boundary, so a period is never cut short.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt   <= '0;
      r_div_q <= DEF_DIV;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 4'd1;
      if (w_tick) r_div_q <= bus.PCLK_DIV;
    end
  end
  // The last REL_A cycle is already PRESETN-eligible: if PCLKEN is high there,
  // skip WAIT_P so the release lands on the first boundary at or after the gap.
  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    case (r_state)
      ASSERT: begin
        w_state_nxt = r_hc == 8'(HOLD_CYCLES - 1) ? REL_A : ASSERT;
        w_hc_nxt    = r_hc == 8'(HOLD_CYCLES - 1) ? '0 : r_hc + 8'd1;
      end
      REL_A: begin
        w_state_nxt = r_hc == 8'(PA_GAP - 1) ? (w_tick ? RUN : WAIT_P) : REL_A;
        w_hc_nxt    = r_hc == 8'(PA_GAP - 1) ? '0 : r_hc + 8'd1;
      end
      WAIT_P: w_state_nxt = w_tick ? RUN : WAIT_P;
      default: w_state_nxt = RUN;
    endcase
    if (bus.SW_RST_REQ) begin
      w_state_nxt = ASSERT;
      w_hc_nxt    = '0;
    end
  end
  // Reset outputs are decoded from the next state so they move on the same edge as the FSM.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= ASSERT;
      r_hc    <= '0;
      r_sys_a <= 1'b0;
      r_sys_p <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hc    <= w_hc_nxt;
      r_sys_a <= w_state_nxt != ASSERT;
      r_sys_p <= w_state_nxt == RUN;
    end
  end
  assign bus.PCLKEN      = w_tick;
  assign bus.SYS_ARESETN = r_sys_a;
  assign bus.SYS_PRESETN = r_sys_p;
  assign bus.RST_BUSY    = r_state != RUN;
endmodule
